// File: rtl/spi_master.sv
// SPI mode-0 initiator: shifts one nbits word out on mosi (MSB first) while capturing miso, framed by cs.
// Optional macro SPI_MASTER_PARITY_EN builds a registered XOR of the captured word on rx_parity.
module spi_master #(
   parameter int nbits    = 34,
   parameter int CLK_HALF = 4,
   parameter int CNT_W    = $clog2(nbits+1),
   parameter int DIV_W    = $clog2(CLK_HALF+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             recv_val,
   input  logic [nbits-1:0] recv_msg,
   output logic             recv_rdy,
   output logic             send_val,
   output logic [nbits-1:0] send_msg,
   input  logic             send_rdy,
   output logic             sclk,
   output logic             cs,
   output logic             mosi,
   input  logic             miso,
   output logic             rx_parity
);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [nbits-1:0] tx_q, tx_d, rx_q, rx_d, smsg_q, smsg_d;
   logic             cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic             rdy_q, rdy_d, sval_q, sval_d;
   logic             phase_end, accept, handshake, done_entry;

   assign phase_end  = (div_q == DIV_W'(CLK_HALF-1));
   assign accept     = (state_q == IDLE) && recv_val && rdy_q;
   assign handshake  = (state_q == DONE) && sval_q && send_rdy;
   assign done_entry = (state_q == HOLD) && (state_d == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         smsg_q  <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         rdy_q   <= 1'b1;
         sval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         smsg_q  <= smsg_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         rdy_q   <= rdy_d;
         sval_q  <= sval_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)    state_d = SETUP;
         SETUP:   if (phase_end) state_d = HIGH;
         HIGH:    if (phase_end) state_d = (cnt_q == CNT_W'(1)) ? HOLD : LOW;
         LOW:     if (phase_end) state_d = HIGH;
         HOLD:    if (phase_end) state_d = DONE;
         DONE:    if (handshake) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_d  = div_q + DIV_W'(1);
      cnt_d  = cnt_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      smsg_d = smsg_q;
      if (state_d != state_q || state_q == IDLE || state_q == DONE)
         div_d = '0;
      if (accept) begin
         tx_d  = recv_msg;
         cnt_d = CNT_W'(nbits);
         rx_d  = '0;
      end
      // miso is taken on the last HIGH cycle, well after the minion's setup
      if (state_q == HIGH && phase_end) begin
         rx_d  = {rx_q[nbits-2:0], miso};
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (state_q == HIGH && state_d == LOW)
         tx_d = {tx_q[nbits-2:0], 1'b0};
      if (done_entry)
         smsg_d = rx_q;
      cs_d   = !(state_d inside {SETUP, HIGH, LOW, HOLD});
      sclk_d = (state_d == HIGH);
      mosi_d = tx_d[nbits-1];
      rdy_d  = (state_d == IDLE);
      // send_val follows DONE by one cycle and drops on the edge that takes the word
      sval_d = (state_q == DONE) && !handshake;
   end

   assign recv_rdy = rdy_q;
   assign send_val = sval_q;
   assign send_msg = smsg_q;
   assign sclk     = sclk_q;
   assign cs       = cs_q;
   assign mosi     = mosi_q;

`ifdef SPI_MASTER_PARITY_EN
   logic par_q;
   always_ff @(posedge clk) begin
      if (reset)           par_q <= 1'b0;
      else if (done_entry) par_q <= ^rx_q;
   end
   assign rx_parity = par_q;
`else
   assign rx_parity = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback/miso-model transfers, backpressure, back-to-back, reset abort, 34-bit minion echo.
`timescale 1ns/1ps
module tb_spi_master;
   localparam int NA = 8, HA = 1, NB = 34, HB = 4;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int total = 0, bad = 0;

   logic          rv_a = 1'b0, sr_a = 1'b1, loop_a = 1'b1;
   logic [NA-1:0] rm_a = '0, mword_a = '0, mcap_a = '0;
   logic          rr_a, sv_a, sclk_a, cs_a, mosi_a, miso_a, par_a;
   logic [NA-1:0] sm_a;
   int            nfall_a = 0, rises_a = 0;

   spi_master #(.nbits(NA), .CLK_HALF(HA)) dut_a (
      .clk(clk), .reset(rst), .recv_val(rv_a), .recv_msg(rm_a), .recv_rdy(rr_a),
      .send_val(sv_a), .send_msg(sm_a), .send_rdy(sr_a), .sclk(sclk_a), .cs(cs_a),
      .mosi(mosi_a), .miso(miso_a), .rx_parity(par_a));

   // miso model: bit for the k-th HIGH is presented after the k-th sclk fall of the frame
   always @(negedge sclk_a or posedge cs_a) if (cs_a) nfall_a = 0; else nfall_a++;
   always @(posedge sclk_a) begin rises_a++; mcap_a = {mcap_a[NA-2:0], mosi_a}; end
   assign miso_a = loop_a ? mosi_a : (nfall_a < NA ? mword_a[3'(NA-1-nfall_a)] : 1'b0);

   logic          rv_b = 1'b0;
   logic [NB-1:0] rm_b = '0, cap_b = '0, stored_b = '0;
   logic          rr_b, sv_b, sclk_b, cs_b, mosi_b, miso_b, par_b;
   logic [NB-1:0] sm_b;
   int            nfall_b = 0;

   spi_master #(.nbits(NB), .CLK_HALF(HB)) dut_b (
      .clk(clk), .reset(rst), .recv_val(rv_b), .recv_msg(rm_b), .recv_rdy(rr_b),
      .send_val(sv_b), .send_msg(sm_b), .send_rdy(1'b1), .sclk(sclk_b), .cs(cs_b),
      .mosi(mosi_b), .miso(miso_b), .rx_parity(par_b));

   // minion stand-in with loopthrough: each frame returns the packet written in the previous frame
   always @(posedge sclk_b) cap_b = {cap_b[NB-2:0], mosi_b};
   always @(posedge cs_b) stored_b = cap_b;
   always @(negedge sclk_b or posedge cs_b) if (cs_b) nfall_b = 0; else nfall_b++;
   assign miso_b = (nfall_b < NB) ? stored_b[6'(NB-1-nfall_b)] : 1'b0;

   function automatic logic exp_par(input logic [NB-1:0] w);
`ifdef SPI_MASTER_PARITY_EN
      return ^w;
`else
      return 1'b0;
`endif
   endfunction

   task automatic xfer_a(input logic [NA-1:0] w, input logic [NA-1:0] mw, input logic loop, input string tag);
      int lat, r0;
      logic [NA-1:0] exp;
      loop_a = loop; mword_a = mw; exp = loop ? w : mw;
      lat = 0;
      while (!rr_a && lat < 100) begin @(posedge clk); #1; lat++; end
      total++; if (rr_a !== 1'b1) begin bad++; $display("FAIL %s rdy_timeout got %b want 1", tag, rr_a); end
      @(negedge clk); rv_a = 1'b1; rm_a = w; r0 = rises_a;
      @(posedge clk); #1; rv_a = 1'b0;
      lat = 0;
      while (!sv_a && lat < 200) begin @(posedge clk); #1; lat++; end
      total++; if (lat !== (2*NA+1)*HA+1) begin bad++; $display("FAIL %s latency got %0d want %0d", tag, lat, (2*NA+1)*HA+1); end
      total++; if (sm_a !== exp) begin bad++; $display("FAIL %s send_msg got %h want %h", tag, sm_a, exp); end
      total++; if (rises_a - r0 !== NA) begin bad++; $display("FAIL %s sclk_rises got %0d want %0d", tag, rises_a - r0, NA); end
      total++; if (mcap_a !== w) begin bad++; $display("FAIL %s mosi_bits got %b want %b", tag, mcap_a, w); end
      total++; if (par_a !== exp_par(NB'(exp))) begin bad++; $display("FAIL %s rx_parity got %b want %b", tag, par_a, exp_par(NB'(exp))); end
      @(posedge clk); #1;
   endtask

   task automatic xfer_b(input logic [NB-1:0] w, output logic [NB-1:0] got, output int lat);
      lat = 0;
      while (!rr_b && lat < 100) begin @(posedge clk); #1; lat++; end
      @(negedge clk); rv_b = 1'b1; rm_b = w;
      @(posedge clk); #1; rv_b = 1'b0;
      lat = 0;
      while (!sv_b && lat < 1000) begin @(posedge clk); #1; lat++; end
      got = sm_b;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (cs_a !== 1'b1)     begin bad++; $display("FAIL reset_cs got %b want 1", cs_a); end
      total++; if (sclk_a !== 1'b0)   begin bad++; $display("FAIL reset_sclk got %b want 0", sclk_a); end
      total++; if (mosi_a !== 1'b0)   begin bad++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
      total++; if (rr_a !== 1'b1)     begin bad++; $display("FAIL reset_rdy got %b want 1", rr_a); end
      total++; if (sv_a !== 1'b0)     begin bad++; $display("FAIL reset_sval got %b want 0", sv_a); end
      total++; if (sm_a !== '0)       begin bad++; $display("FAIL reset_smsg got %h want 0", sm_a); end
      total++; if (par_a !== 1'b0)    begin bad++; $display("FAIL reset_parity got %b want 0", par_a); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_loopback();
      xfer_a(8'hA5, 8'h00, 1'b1, "loop_A5");
      xfer_a(8'hFF, 8'h3C, 1'b0, "miso_3C");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         xfer_a(NA'($urandom), NA'($urandom), 1'($urandom_range(0, 1)), "random");
   endtask

   task automatic test_backpressure();
      int lat;
      sr_a = 1'b0; loop_a = 1'b1;
      @(negedge clk); rv_a = 1'b1; rm_a = 8'hC3;
      @(posedge clk); #1; rv_a = 1'b0;
      lat = 0;
      while (!sv_a && lat < 200) begin @(posedge clk); #1; lat++; end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         total++; if (sv_a !== 1'b1)  begin bad++; $display("FAIL bp_sval cyc %0d got %b want 1", c, sv_a); end
         total++; if (sm_a !== 8'hC3) begin bad++; $display("FAIL bp_smsg cyc %0d got %h want c3", c, sm_a); end
         total++; if (rr_a !== 1'b0)  begin bad++; $display("FAIL bp_rdy cyc %0d got %b want 0", c, rr_a); end
         total++; if (cs_a !== 1'b1)  begin bad++; $display("FAIL bp_cs cyc %0d got %b want 1", c, cs_a); end
      end
      @(negedge clk); sr_a = 1'b1;
      @(posedge clk); #1;
      total++; if (sv_a !== 1'b0) begin bad++; $display("FAIL bp_release_sval got %b want 0", sv_a); end
      total++; if (rr_a !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got %b want 1", rr_a); end
   endtask

   task automatic test_back_to_back();
      int acc = 0, hs = 0, cyc = 0, run = 0, minrun = 1000;
      bit seen_low = 0;
      logic [NA-1:0] exp;
      loop_a = 1'b1; sr_a = 1'b1; rv_a = 1'b1; rm_a = 8'h01;
      while (hs < 2 && cyc < 300) begin
         @(negedge clk); cyc++;
         if (acc == 1) rm_a = 8'h80;
         if (acc == 2) rv_a = 1'b0;
         if (rr_a && rv_a) begin
            acc++;
            if (acc == 2) begin
               total++; if (hs !== 1) begin bad++; $display("FAIL b2b_order got hs=%0d want 1", hs); end
            end
         end
         if (sv_a && sr_a) begin
            exp = (hs == 0) ? 8'h01 : 8'h80;
            total++; if (sm_a !== exp) begin bad++; $display("FAIL b2b_word%0d got %h want %h", hs, sm_a, exp); end
            total++; if (rr_a !== 1'b0) begin bad++; $display("FAIL b2b_no_accept_in_done got %b want 0", rr_a); end
            hs++;
         end
         if (cs_a) run++;
         else begin
            if (seen_low && run > 0 && run < minrun) minrun = run;
            seen_low = 1; run = 0;
         end
      end
      rv_a = 1'b0;
      total++; if (hs !== 2) begin bad++; $display("FAIL b2b_count got %0d want 2", hs); end
      total++; if (minrun < 1 || minrun == 1000) begin bad++; $display("FAIL b2b_cs_gap got %0d want >=1", minrun); end
   endtask

   task automatic test_reset_abort();
      int r0, c = 0;
      loop_a = 1'b1;
      @(negedge clk); rv_a = 1'b1; rm_a = 8'hFF; r0 = rises_a;
      @(posedge clk); #1; rv_a = 1'b0;
      while (rises_a - r0 < 4 && c < 100) begin @(negedge clk); c++; end
      total++; if (sclk_a !== 1'b1) begin bad++; $display("FAIL abort_in_high got %b want 1", sclk_a); end
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (cs_a !== 1'b1)   begin bad++; $display("FAIL abort_cs got %b want 1", cs_a); end
      total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL abort_sclk got %b want 0", sclk_a); end
      total++; if (rr_a !== 1'b1)   begin bad++; $display("FAIL abort_rdy got %b want 1", rr_a); end
      total++; if (sv_a !== 1'b0)   begin bad++; $display("FAIL abort_sval got %b want 0", sv_a); end
      @(negedge clk); rst = 1'b0;
      xfer_a(8'h5A, 8'h00, 1'b1, "after_abort");
   endtask

   task automatic test_full_stack();
      logic [NB-1:0] got;
      int lat;
      xfer_b({2'b11, 32'hDEADBEEF}, got, lat);
      total++; if (lat !== (2*NB+1)*HB+1) begin bad++; $display("FAIL fs_latency got %0d want %0d", lat, (2*NB+1)*HB+1); end
      total++; if (got !== '0) begin bad++; $display("FAIL fs_first_read got %h want 0", got); end
      xfer_b({2'b10, 32'h0}, got, lat);
      total++; if (got[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL fs_data got %h want deadbeef", got[31:0]); end
      total++; if (got[33:32] !== 2'b11) begin bad++; $display("FAIL fs_flags got %b want 11", got[33:32]); end
      total++; if (par_b !== exp_par({2'b11, 32'hDEADBEEF})) begin bad++; $display("FAIL fs_parity got %b want %b", par_b, exp_par({2'b11, 32'hDEADBEEF})); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_full_stack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
